// File: rtl/alu_sequencer_65c02.sv
// alu_sequencer_65c02: registered 65C02 ALU stage that feeds the 8-bit accumulator.
// Each accepted op is captured, executed in EXEC and published as a one-cycle result.
// Optional feature macro ALU_BCD_EN: when defined, decimal ADC/SBC take an extra DADJ
// cycle for BCD correction; when undefined, decimal_mode is ignored.
module alu_sequencer_65c02 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [3:0]       op_sel,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             carry_in,
   input  logic             decimal_mode,
   output logic [WIDTH-1:0] alu_result,
   output logic             alu_to_accumulator_xfer,
   output logic             result_valid,
   output logic             flag_n,
   output logic             flag_v,
   output logic             flag_z,
   output logic             flag_c,
   output logic [3:0]       flag_we
);

   localparam logic [3:0] OP_ADC = 4'd0;
   localparam logic [3:0] OP_SBC = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_ORA = 4'd3;
   localparam logic [3:0] OP_EOR = 4'd4;
   localparam logic [3:0] OP_CMP = 4'd5;
   localparam logic [3:0] OP_BIT = 4'd6;
   localparam logic [3:0] OP_ASL = 4'd7;
   localparam logic [3:0] OP_LSR = 4'd8;
   localparam logic [3:0] OP_ROL = 4'd9;
   localparam logic [3:0] OP_ROR = 4'd10;
   localparam logic [3:0] OP_INC = 4'd11;
   localparam logic [3:0] OP_DEC = 4'd12;

   // Flag enables, ordered {N,V,Z,C}
   localparam logic [3:0] WE_NVZC = 4'b1111;
   localparam logic [3:0] WE_NZ   = 4'b1010;
   localparam logic [3:0] WE_NZC  = 4'b1011;
   localparam logic [3:0] WE_NVZ  = 4'b1110;

`ifdef ALU_BCD_EN
   typedef enum logic [1:0] {IDLE, EXEC, DADJ} state_t;
`else
   typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif

   state_t           state;

   // Operands captured at accept; held stable for the whole op
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             c_q;

   logic [WIDTH:0]   sum_c;
   logic [WIDTH:0]   dif_c;
   logic [WIDTH:0]   cmp_c;
   logic [WIDTH-1:0] bin_res;
   logic             bin_n;
   logic             bin_v;
   logic             bin_z;
   logic             bin_c;
   logic [3:0]       we_sel;
   logic             xfer_sel;

   // Binary ALU on the captured operands
   always_comb begin
      sum_c    = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, c_q};
      dif_c    = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, c_q};
      cmp_c    = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
      bin_res  = b_q;
      bin_v    = 1'b0;
      bin_c    = 1'b0;
      we_sel   = WE_NZ;
      xfer_sel = 1'b1;
      case (op_q)
         OP_ADC: begin
            bin_res = sum_c[WIDTH-1:0];
            bin_c   = sum_c[WIDTH];
            bin_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
            we_sel  = WE_NVZC;
         end
         OP_SBC: begin
            bin_res = dif_c[WIDTH-1:0];
            bin_c   = dif_c[WIDTH];
            bin_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_c[WIDTH-1] != a_q[WIDTH-1]);
            we_sel  = WE_NVZC;
         end
         OP_AND: bin_res = a_q & b_q;
         OP_ORA: bin_res = a_q | b_q;
         OP_EOR: bin_res = a_q ^ b_q;
         OP_CMP: begin
            bin_res  = a_q;
            bin_c    = cmp_c[WIDTH];
            we_sel   = WE_NZC;
            xfer_sel = 1'b0;
         end
         OP_BIT: begin
            bin_res  = a_q;
            bin_v    = b_q[WIDTH-2];
            we_sel   = WE_NVZ;
            xfer_sel = 1'b0;
         end
         OP_ASL: begin
            bin_res = {b_q[WIDTH-2:0], 1'b0};
            bin_c   = b_q[WIDTH-1];
            we_sel  = WE_NZC;
         end
         OP_LSR: begin
            bin_res = {1'b0, b_q[WIDTH-1:1]};
            bin_c   = b_q[0];
            we_sel  = WE_NZC;
         end
         OP_ROL: begin
            bin_res = {b_q[WIDTH-2:0], c_q};
            bin_c   = b_q[WIDTH-1];
            we_sel  = WE_NZC;
         end
         OP_ROR: begin
            bin_res = {c_q, b_q[WIDTH-1:1]};
            bin_c   = b_q[0];
            we_sel  = WE_NZC;
         end
         OP_INC:  bin_res = b_q + WIDTH'(1);
         OP_DEC:  bin_res = b_q - WIDTH'(1);
         default: bin_res = b_q;
      endcase
      bin_n = bin_res[WIDTH-1];
      bin_z = (bin_res == '0);
      if (op_q == OP_CMP) begin
         bin_n = cmp_c[WIDTH-1];
         bin_z = (cmp_c[WIDTH-1:0] == '0);
      end else if (op_q == OP_BIT) begin
         bin_n = b_q[WIDTH-1];
         bin_z = ((a_q & b_q) == '0);
      end
   end

`ifdef ALU_BCD_EN
   logic             d_q;
   logic [5:0]       lo_raw;
   logic [5:0]       lo_adj;
   logic [5:0]       hi_raw;
   logic [5:0]       hi_adj;
   logic             lo_borrow;
   logic [WIDTH-1:0] dec_res;
   logic             dec_c;
   logic             bcd_op;

   // Nibble-wise BCD correction; V still comes from the binary path
   always_comb begin
      lo_raw    = {2'b00, a_q[3:0]} + {2'b00, b_q[3:0]} + {5'b00000, c_q};
      lo_adj    = (lo_raw > 6'd9) ? lo_raw + 6'd6 : lo_raw;
      hi_raw    = {2'b00, a_q[7:4]} + {2'b00, b_q[7:4]} + {5'b00000, (lo_adj > 6'd15)};
      hi_adj    = (hi_raw > 6'd9) ? hi_raw + 6'd6 : hi_raw;
      lo_borrow = (({1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0000, c_q}) < 5'd16);
      bcd_op    = d_q && ((op_q == OP_ADC) || (op_q == OP_SBC));
      if (op_q == OP_SBC) begin
         dec_res = dif_c[WIDTH-1:0]
                   - (lo_borrow    ? 8'h06 : 8'h00)
                   - (dif_c[WIDTH] ? 8'h00 : 8'h60);
         dec_c   = dif_c[WIDTH];
      end else begin
         dec_res = {hi_adj[3:0], lo_adj[3:0]};
         dec_c   = (hi_adj > 6'd15);
      end
   end
`else
   logic unused_decimal_mode;
   assign unused_decimal_mode = decimal_mode;
`endif

   // Sequencer: capture, execute, optional decimal adjust, publish registered results
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                   <= IDLE;
         op_ready                <= 1'b1;
         op_q                    <= '0;
         a_q                     <= '0;
         b_q                     <= '0;
         c_q                     <= 1'b0;
`ifdef ALU_BCD_EN
         d_q                     <= 1'b0;
`endif
         alu_result              <= '0;
         alu_to_accumulator_xfer <= 1'b0;
         result_valid            <= 1'b0;
         flag_n                  <= 1'b0;
         flag_v                  <= 1'b0;
         flag_z                  <= 1'b0;
         flag_c                  <= 1'b0;
         flag_we                 <= 4'b0000;
      end else begin
         result_valid            <= 1'b0;
         alu_to_accumulator_xfer <= 1'b0;
         flag_we                 <= 4'b0000;
         case (state)
            IDLE: begin
               if (op_valid && op_ready) begin
                  op_q     <= op_sel;
                  a_q      <= a_in;
                  b_q      <= b_in;
                  c_q      <= carry_in;
`ifdef ALU_BCD_EN
                  d_q      <= decimal_mode;
`endif
                  op_ready <= 1'b0;
                  state    <= EXEC;
               end
            end
            EXEC: begin
`ifdef ALU_BCD_EN
               if (bcd_op) state <= DADJ;
               else
`endif
               begin
                  alu_result              <= bin_res;
                  if (we_sel[3]) flag_n   <= bin_n;
                  if (we_sel[2]) flag_v   <= bin_v;
                  if (we_sel[1]) flag_z   <= bin_z;
                  if (we_sel[0]) flag_c   <= bin_c;
                  flag_we                 <= we_sel;
                  result_valid            <= 1'b1;
                  alu_to_accumulator_xfer <= xfer_sel;
                  op_ready                <= 1'b1;
                  state                   <= IDLE;
               end
            end
`ifdef ALU_BCD_EN
            DADJ: begin
               alu_result              <= dec_res;
               flag_n                  <= dec_res[WIDTH-1];
               flag_v                  <= bin_v;
               flag_z                  <= (dec_res == '0);
               flag_c                  <= dec_c;
               flag_we                 <= WE_NVZC;
               result_valid            <= 1'b1;
               alu_to_accumulator_xfer <= 1'b1;
               op_ready                <= 1'b1;
               state                   <= IDLE;
            end
`endif
            default: begin
               op_ready <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_sequencer_65c02.md
Name: alu_sequencer_65c02

Overview:
- Registered ALU stage directly upstream of the 8-bit accumulator.
- Takes the accumulator value plus a data-bus operand and computes a 65C02 ALU operation. Drives the accumulator's alu_in, a one-cycle alu_to_accumulator_xfer strobe, and NVZC flag updates for the status register.
- Decimal-mode ADC/SBC take one extra cycle, matching 65C02 timing.

Parameters:
- WIDTH, 8, datapath width. Only 8 is supported; BCD logic assumes two nibbles.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  operation request.
- op_ready  output  1  high in IDLE only; an op is accepted when op_valid && op_ready.
- op_sel  input  4  0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 CMP, 6 BIT, 7 ASL, 8 LSR, 9 ROL, 10 ROR, 11 INC, 12 DEC, 13-15 PASS (B).
- a_in  input  8  operand A, from the accumulator's alu_out.
- b_in  input  8  operand B, from the data bus or operand latch.
- carry_in  input  1  current C flag.
- decimal_mode  input  1  current D flag.
- alu_result  output  8  result, to the accumulator's alu_in.
- alu_to_accumulator_xfer  output  1  one-cycle strobe telling the accumulator to load alu_result.
- result_valid  output  1  one-cycle pulse: result and flags valid.
- flag_n, flag_v, flag_z, flag_c  output  1 each  computed flags.
- flag_we  output  4  {N,V,Z,C} update enables, qualified by result_valid.

Behaviour:
- States: IDLE, EXEC, DADJ.
- Reset (async, any state): state=IDLE; alu_result=0; all flags=0; flag_we=0; result_valid=0; xfer=0. Any in-flight op is discarded.
- IDLE:
  - op_ready=1.
  - On accept, capture op_sel, a_in, b_in, carry_in and decimal_mode into internal registers, then go to EXEC.
  - Inputs are not sampled again until the next accept.
- EXEC:
  - Compute the binary result into registers.
  - If op is ADC/SBC and the captured D=1: go to DADJ, with no result_valid yet.
  - Otherwise: assert result_valid next cycle and return to IDLE.
  - Latency: accept at edge T0 → result_valid high in the cycle after edge T1.
- DADJ:
  - Apply BCD correction, assert result_valid, return to IDLE.
  - Latency is T0 → T2.
- op_valid while op_ready=0 is ignored; the requester must hold it.
- Throughput: one op per 2 cycles (binary) or 3 cycles (decimal).
- Binary arithmetic:
  - ADC: {C,R} = A+B+Cin; V = (A7==B7)&&(R7!=A7).
  - SBC: A+~B+Cin, with the same V rule applied to ~B; C = no borrow.
- Decimal ADC:
  - lo = A[3:0]+B[3:0]+Cin; if lo>9, lo+=6.
  - hi = A[7:4]+B[7:4]+(lo>15); if hi>9, hi+=6.
  - C = hi>15; R = {hi[3:0],lo[3:0]}.
- Decimal SBC:
  - Start from the binary difference.
  - Low-nibble borrow → subtract 0x06. Overall borrow → subtract 0x60.
  - C = binary no-borrow.
- Flags in decimal mode: V comes from the binary computation; N and Z come from the final BCD result (65C02 semantics).
- CMP: A−B with carry forced to 1. Sets N, Z, C. alu_result = A. xfer=0.
- BIT: N=B7, V=B6, Z=((A&B)==0). alu_result = A. xfer=0.
- Shifts and rotates:
  - ASL/ROL: C=B7. LSR/ROR: C=B0.
  - ROL shifts Cin into bit 0; ROR shifts Cin into bit 7.
  - Operate on B; A-register forms place A on b_in.
- INC/DEC: B±1, wrapping 0xFF↔0x00. Only N and Z are updated.
- flag_we per op:
  - ADC/SBC: NVZC.
  - AND/ORA/EOR/INC/DEC/PASS: NZ.
  - CMP: NZC.
  - BIT: NVZ.
  - Shifts/rotates: NZC.
- alu_to_accumulator_xfer = result_valid for every op except CMP and BIT.
- All outputs are registered. flag_we, xfer and result_valid are 0 outside the result cycle; alu_result and flags hold their last value.

Optional Feature:
- ALU_BCD_EN defined: decimal_mode is honoured and the DADJ state exists, as above.
- ALU_BCD_EN undefined: decimal_mode is ignored, DADJ is removed, and ADC/SBC always complete binary with two-cycle latency.

Test Plan:
- ADC, D=0, A=0x50, B=0x50, Cin=0 → result 0x50+0x50=0xA0; N=1 V=1 Z=0 C=0; result_valid and xfer in the cycle after edge T1.
- ADC, D=1, A=0x58, B=0x46, Cin=1 → 0x05, C=1, Z=0; result_valid after edge T2. With ALU_BCD_EN undefined → 0x9F, C=0, after edge T1.
- SBC, D=1, A=0x46, B=0x12, Cin=1 → 0x34, C=1. SBC, D=0, A=0x00, B=0x01, Cin=1 → 0xFF, C=0, N=1.
- CMP A=0x40, B=0x41 → C=0, N=1, Z=0, flag_we=1011, xfer=0, alu_result=0x40. BIT A=0x0F, B=0xC0 → N=1, V=1, Z=1.
- ROR B=0x01, Cin=1 → 0x80, C=1, N=1. DEC B=0x00 → 0xFF, flag_we=1010.
- Decimal ADC, assert reset while in DADJ → no result_valid or xfer pulse; all outputs 0; op_ready=1 after release. op_valid held during EXEC is not accepted until IDLE.
